// File: rtl/wb_port_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// wb_port_arbiter_pkg
// Shared definitions for the regfile write-port arbiter:
//   - register address width and the WB-to-ID bus width ({we, waddr, wdata})
//   - grant source encoding
//   - helper that decides whether a beat really writes the regfile (x0 filter)
// -----------------------------------------------------------------------------
package wb_port_arbiter_pkg;

  localparam int DEFAULT_XLEN       = 32;
  localparam int REG_ADDR_WIDTH     = 5;
  // {rf_we, rf_waddr, rf_wdata} packs to this width, so the arbiter output can
  // stand in for the wb stage bus towards ID.
  localparam int WB_TO_ID_BUS_WIDTH = 1 + REG_ADDR_WIDTH + DEFAULT_XLEN;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_PIPE = 2'd1,
    GNT_FIFO = 2'd2
  } grant_src_e;

  // A write to x0 is architecturally a no-op, so it never counts as a request.
  function automatic logic is_rf_write(input logic                      we,
                                       input logic [REG_ADDR_WIDTH-1:0] waddr);
    return we & (waddr != {REG_ADDR_WIDTH{1'b0}});
  endfunction

endpackage

// File: rtl/wb_arb_fifo.sv
// -----------------------------------------------------------------------------
// wb_arb_fifo
// Small synchronous FIFO buffering MDU results ({waddr, wdata}) until the
// regfile write port is granted to them. Reset discards all contents.
// Ports:
//   clk_i, rst_i         clock, asynchronous active-high reset
//   push_i / wdata_i     enqueue request and payload (ignored when full)
//   pop_i  / rdata_o     dequeue request and head payload (ignored when empty)
//   full_o, empty_o      occupancy flags (registered state only)
//   count_o              occupied entries
// -----------------------------------------------------------------------------
module wb_arb_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 37
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           wdata_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           rdata_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q,  count_d;
  logic             do_push_s, do_pop_s;

  assign full_o    = (count_q == DEPTH_C);
  assign empty_o   = (count_q == {CNT_W{1'b0}});
  assign count_o   = count_q;
  assign rdata_o   = mem_q[rd_ptr_q];
  assign do_push_s = push_i & ~full_o;
  assign do_pop_s  = pop_i & ~empty_o;

  // Next-state for pointers and occupancy; pointers wrap naturally (DEPTH is 2^n).
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push_s) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (do_pop_s) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({do_push_s, do_pop_s})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers; reset empties the FIFO.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      count_q  <= {CNT_W{1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage; contents are don't-care while not counted as occupied.
  always_ff @(posedge clk_i) begin
    if (do_push_s) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// -----------------------------------------------------------------------------
// wb_port_arbiter
// Shares the single regfile write port between the MEM->WB pipeline beat and
// the long-latency MDU. MDU results wait in a small FIFO; the pipeline has
// priority, but a FIFO head denied MAX_WAIT times is force-granted while the
// pipeline is held off through pipe_allow_in.
// Ports:
//   clk, rst                                  clock, async active-high reset
//   pipe_valid/we/waddr/wdata, pipe_allow_in  pipeline writeback beat
//   mdu_valid/waddr/wdata, mdu_ready          MDU result handshake
//   rf_we/rf_waddr/rf_wdata                   registered regfile write port
//   fifo_count                                buffered MDU results
//   starve_grant                              forced MDU grant this cycle
// -----------------------------------------------------------------------------
module wb_port_arbiter
  import wb_port_arbiter_pkg::*;
#(
  parameter int XLEN       = DEFAULT_XLEN,
  parameter int FIFO_DEPTH = 2,
  parameter int MAX_WAIT   = 3
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            pipe_valid,
  output logic                            pipe_allow_in,
  input  logic                            pipe_we,
  input  logic [REG_ADDR_WIDTH-1:0]       pipe_waddr,
  input  logic [XLEN-1:0]                 pipe_wdata,
  input  logic                            mdu_valid,
  output logic                            mdu_ready,
  input  logic [REG_ADDR_WIDTH-1:0]       mdu_waddr,
  input  logic [XLEN-1:0]                 mdu_wdata,
  output logic                            rf_we,
  output logic [REG_ADDR_WIDTH-1:0]       rf_waddr,
  output logic [XLEN-1:0]                 rf_wdata,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count,
  output logic                            starve_grant
);

  localparam int PLD_W  = REG_ADDR_WIDTH + XLEN;
  localparam int WAIT_W = $clog2(MAX_WAIT+1);
  localparam logic [WAIT_W-1:0] MAX_WAIT_C = WAIT_W'(MAX_WAIT);

  logic [PLD_W-1:0]          head_s;
  logic                      full_s, empty_s;
  logic                      push_s, pop_s;
  logic                      force_s, pipe_req_s;
  grant_src_e                grant_s;

  logic [WAIT_W-1:0]         wait_cnt_q, wait_cnt_d;
  logic                      rf_we_q,    rf_we_d;
  logic [REG_ADDR_WIDTH-1:0] rf_waddr_q, rf_waddr_d;
  logic [XLEN-1:0]           rf_wdata_q, rf_wdata_d;

  wb_arb_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (PLD_W)
  ) u_fifo (
    .clk_i   (clk),
    .rst_i   (rst),
    .push_i  (push_s),
    .wdata_i ({mdu_waddr, mdu_wdata}),
    .pop_i   (pop_s),
    .rdata_o (head_s),
    .full_o  (full_s),
    .empty_o (empty_s),
    .count_o (fifo_count)
  );

  // Ready depends only on registered occupancy, so a same-cycle pop never
  // opens a slot for a push.
  assign mdu_ready     = ~full_s;
  // x0 results complete the handshake but are dropped here.
  assign push_s        = mdu_valid & mdu_ready & is_rf_write(1'b1, mdu_waddr);
  assign pop_s         = (grant_s == GNT_FIFO);
  assign pipe_allow_in = ~force_s;
  assign starve_grant  = force_s;

  // Priority grant: starved FIFO head, then writing pipeline beat, then FIFO.
  always_comb begin
    force_s    = ~empty_s & (wait_cnt_q == MAX_WAIT_C);
    pipe_req_s = pipe_valid & is_rf_write(pipe_we, pipe_waddr);
    grant_s    = GNT_NONE;
    if (force_s) begin
      grant_s = GNT_FIFO;
    end else if (pipe_req_s) begin
      grant_s = GNT_PIPE;
    end else if (!empty_s) begin
      grant_s = GNT_FIFO;
    end else begin
      grant_s = GNT_NONE;
    end
  end

  // Starvation counter and write-port next state; address/data hold when idle.
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    rf_we_d    = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    if (pop_s || empty_s) begin
      wait_cnt_d = {WAIT_W{1'b0}};
    end else if (wait_cnt_q != MAX_WAIT_C) begin
      wait_cnt_d = wait_cnt_q + 1'b1;
    end else begin
      wait_cnt_d = wait_cnt_q;
    end
    case (grant_s)
      GNT_PIPE: begin
        rf_we_d    = 1'b1;
        rf_waddr_d = pipe_waddr;
        rf_wdata_d = pipe_wdata;
      end
      GNT_FIFO: begin
        rf_we_d                  = 1'b1;
        {rf_waddr_d, rf_wdata_d} = head_s;
      end
      default: begin
        rf_we_d    = 1'b0;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
      end
    endcase
  end

  // Registered write port and starvation counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt_q <= {WAIT_W{1'b0}};
      rf_we_q    <= 1'b0;
      rf_waddr_q <= {REG_ADDR_WIDTH{1'b0}};
      rf_wdata_q <= {XLEN{1'b0}};
    end else begin
      wait_cnt_q <= wait_cnt_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
    end
  end

  assign rf_we    = rf_we_q;
  assign rf_waddr = rf_waddr_q;
  assign rf_wdata = rf_wdata_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_wb_port_arbiter
// Self-checking bench for wb_port_arbiter. A behavioural model (a queue of
// pending MDU results plus a denial counter) predicts every cycle's outputs.
// Inputs change on the falling edge; combinational outputs are sampled just
// after that, registered outputs on the next falling edge.
// -----------------------------------------------------------------------------
module tb_wb_port_arbiter;

  localparam int XLEN     = 32;
  localparam int DEPTH    = 2;
  localparam int MAX_WAIT = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        pipe_valid, pipe_allow_in, pipe_we;
  logic [4:0]  pipe_waddr;
  logic [31:0] pipe_wdata;
  logic        mdu_valid, mdu_ready;
  logic [4:0]  mdu_waddr;
  logic [31:0] mdu_wdata;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [1:0]  fifo_count;
  logic        starve_grant;

  int n_cmp = 0;
  int n_err = 0;

  // reference model state
  logic [36:0] mq[$];
  int          mwait;
  logic        exp_we;
  logic [4:0]  exp_waddr;
  logic [31:0] exp_wdata;
  logic        exp_allow, exp_starve, exp_ready;
  logic [1:0]  exp_count_pre;
  // DUT combinational outputs sampled before the active edge
  logic        obs_allow, obs_starve, obs_ready;
  logic [1:0]  obs_count_pre;

  wb_port_arbiter #(.XLEN(XLEN), .FIFO_DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst(rst),
    .pipe_valid(pipe_valid), .pipe_allow_in(pipe_allow_in), .pipe_we(pipe_we),
    .pipe_waddr(pipe_waddr), .pipe_wdata(pipe_wdata),
    .mdu_valid(mdu_valid), .mdu_ready(mdu_ready),
    .mdu_waddr(mdu_waddr), .mdu_wdata(mdu_wdata),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .fifo_count(fifo_count), .starve_grant(starve_grant)
  );

  always #5 clk = ~clk;

  task automatic set_pipe(input logic v, input logic we, input logic [4:0] a, input logic [31:0] d);
    pipe_valid = v; pipe_we = we; pipe_waddr = a; pipe_wdata = d;
  endtask

  task automatic set_mdu(input logic v, input logic [4:0] a, input logic [31:0] d);
    mdu_valid = v; mdu_waddr = a; mdu_wdata = d;
  endtask

  task automatic model_reset();
    mq.delete();
    mwait = 0; exp_we = 1'b0; exp_waddr = 5'd0; exp_wdata = 32'd0;
  endtask

  // One clock cycle: predict from the rules, sample, advance the model.
  task automatic tick();
    logic        frc, preq, gpipe, gfifo, push;
    logic [36:0] head;
    #1;
    frc           = (mq.size() != 0) && (mwait == MAX_WAIT);
    exp_allow     = !frc;
    exp_starve    = frc;
    exp_ready     = (mq.size() < DEPTH);
    exp_count_pre = 2'(mq.size());
    obs_allow     = pipe_allow_in;
    obs_starve    = starve_grant;
    obs_ready     = mdu_ready;
    obs_count_pre = fifo_count;
    preq  = pipe_valid && pipe_we && (pipe_waddr != 5'd0);
    gpipe = !frc && preq;
    gfifo = (mq.size() != 0) && !gpipe;
    push  = mdu_valid && exp_ready && (mdu_waddr != 5'd0);
    @(posedge clk);
    if (gfifo) begin
      head = mq.pop_front();
      exp_we = 1'b1; exp_waddr = head[36:32]; exp_wdata = head[31:0];
      mwait = 0;
    end else if (gpipe) begin
      exp_we = 1'b1; exp_waddr = pipe_waddr; exp_wdata = pipe_wdata;
      mwait = (mq.size() == 0) ? 0 : ((mwait < MAX_WAIT) ? mwait + 1 : MAX_WAIT);
    end else begin
      exp_we = 1'b0;
      mwait = 0;
    end
    if (push) mq.push_back({mdu_waddr, mdu_wdata});
    @(negedge clk);
  endtask

  task automatic idle();
    set_pipe(1'b0, 1'b0, 5'd0, 32'd0);
    set_mdu(1'b0, 5'd0, 32'd0);
  endtask

  task automatic test_reset();
    #2;
    n_cmp++; if (rf_we !== 1'b0) begin n_err++; $display("FAIL reset_rf_we: got %0h want 0", rf_we); end
    n_cmp++; if (rf_waddr !== 5'd0) begin n_err++; $display("FAIL reset_rf_waddr: got %0h want 0", rf_waddr); end
    n_cmp++; if (rf_wdata !== 32'd0) begin n_err++; $display("FAIL reset_rf_wdata: got %0h want 0", rf_wdata); end
    n_cmp++; if (fifo_count !== 2'd0) begin n_err++; $display("FAIL reset_count: got %0h want 0", fifo_count); end
    n_cmp++; if (starve_grant !== 1'b0) begin n_err++; $display("FAIL reset_starve: got %0h want 0", starve_grant); end
    n_cmp++; if (mdu_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %0h want 1", mdu_ready); end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    tick();
    n_cmp++; if (rf_we !== 1'b0) begin n_err++; $display("FAIL reset_release_we: got %0h want 0", rf_we); end
  endtask

  task automatic test_pipe_only();
    set_pipe(1'b1, 1'b1, 5'd5, 32'hDEADBEEF);
    tick();
    n_cmp++; if (obs_allow !== 1'b1) begin n_err++; $display("FAIL pipe_allow: got %0h want 1", obs_allow); end
    n_cmp++; if (rf_we !== 1'b1) begin n_err++; $display("FAIL pipe_we: got %0h want 1", rf_we); end
    n_cmp++; if (rf_waddr !== 5'd5) begin n_err++; $display("FAIL pipe_waddr: got %0h want 5", rf_waddr); end
    n_cmp++; if (rf_wdata !== 32'hDEADBEEF) begin n_err++; $display("FAIL pipe_wdata: got %0h want deadbeef", rf_wdata); end
    set_pipe(1'b1, 1'b1, 5'd0, 32'h00001234);
    tick();
    n_cmp++; if (rf_we !== 1'b0) begin n_err++; $display("FAIL pipe_x0_we: got %0h want 0", rf_we); end
    n_cmp++; if (rf_waddr !== 5'd5) begin n_err++; $display("FAIL pipe_x0_hold: got %0h want 5", rf_waddr); end
    idle();
    tick();
  endtask

  task automatic test_mdu_only();
    set_mdu(1'b1, 5'd7, 32'h12345678);
    tick();
    idle();
    n_cmp++; if (fifo_count !== 2'd1) begin n_err++; $display("FAIL mdu_count1: got %0h want 1", fifo_count); end
    n_cmp++; if (rf_we !== 1'b0) begin n_err++; $display("FAIL mdu_no_bypass: got %0h want 0", rf_we); end
    tick();
    n_cmp++; if (rf_we !== 1'b1) begin n_err++; $display("FAIL mdu_we: got %0h want 1", rf_we); end
    n_cmp++; if (rf_waddr !== 5'd7) begin n_err++; $display("FAIL mdu_waddr: got %0h want 7", rf_waddr); end
    n_cmp++; if (rf_wdata !== 32'h12345678) begin n_err++; $display("FAIL mdu_wdata: got %0h want 12345678", rf_wdata); end
    n_cmp++; if (fifo_count !== 2'd0) begin n_err++; $display("FAIL mdu_count0: got %0h want 0", fifo_count); end
    set_mdu(1'b1, 5'd0, 32'hFFFFFFFF);
    tick();
    idle();
    n_cmp++; if (fifo_count !== 2'd0) begin n_err++; $display("FAIL mdu_x0_drop: got %0h want 0", fifo_count); end
    tick();
  endtask

  task automatic test_starvation();
    set_pipe(1'b1, 1'b1, 5'd1, 32'h100);
    set_mdu(1'b1, 5'd9, 32'hA5);
    tick();
    set_mdu(1'b0, 5'd0, 32'd0);
    for (int i = 2; i <= 4; i++) begin
      set_pipe(1'b1, 1'b1, 5'(i), 32'(i));
      tick();
      n_cmp++; if (obs_starve !== 1'b0) begin n_err++; $display("FAIL starve_early[%0d]: got %0h want 0", i, obs_starve); end
      n_cmp++; if (rf_waddr !== 5'(i)) begin n_err++; $display("FAIL starve_pipe_waddr[%0d]: got %0h want %0h", i, rf_waddr, i); end
    end
    set_pipe(1'b1, 1'b1, 5'd5, 32'h555);
    tick();
    n_cmp++; if (obs_allow !== 1'b0) begin n_err++; $display("FAIL starve_allow: got %0h want 0", obs_allow); end
    n_cmp++; if (obs_starve !== 1'b1) begin n_err++; $display("FAIL starve_grant: got %0h want 1", obs_starve); end
    n_cmp++; if (rf_waddr !== 5'd9) begin n_err++; $display("FAIL starve_waddr: got %0h want 9", rf_waddr); end
    n_cmp++; if (rf_wdata !== 32'hA5) begin n_err++; $display("FAIL starve_wdata: got %0h want a5", rf_wdata); end
    tick();
    n_cmp++; if (obs_allow !== 1'b1) begin n_err++; $display("FAIL starve_allow_back: got %0h want 1", obs_allow); end
    n_cmp++; if (rf_waddr !== 5'd5) begin n_err++; $display("FAIL starve_held_beat: got %0h want 5", rf_waddr); end
    idle();
    tick();
  endtask

  task automatic test_full_fifo();
    set_pipe(1'b1, 1'b1, 5'd3, 32'h3);
    set_mdu(1'b1, 5'd10, 32'hA);
    tick();
    set_pipe(1'b1, 1'b1, 5'd4, 32'h4);
    set_mdu(1'b1, 5'd11, 32'hB);
    tick();
    n_cmp++; if (fifo_count !== 2'd2) begin n_err++; $display("FAIL full_count2: got %0h want 2", fifo_count); end
    set_pipe(1'b1, 1'b1, 5'd5, 32'h5);
    set_mdu(1'b1, 5'd12, 32'hC);
    tick();
    n_cmp++; if (obs_ready !== 1'b0) begin n_err++; $display("FAIL full_ready: got %0h want 0", obs_ready); end
    tick();
    tick();
    n_cmp++; if (obs_starve !== 1'b1) begin n_err++; $display("FAIL full_force: got %0h want 1", obs_starve); end
    n_cmp++; if (obs_ready !== 1'b0) begin n_err++; $display("FAIL full_ready_on_pop: got %0h want 0", obs_ready); end
    n_cmp++; if (fifo_count !== 2'd1) begin n_err++; $display("FAIL full_no_push: got %0h want 1", fifo_count); end
    n_cmp++; if (rf_waddr !== 5'd10) begin n_err++; $display("FAIL full_pop_order: got %0h want a", rf_waddr); end
    tick();
    n_cmp++; if (obs_ready !== 1'b1) begin n_err++; $display("FAIL full_ready_next: got %0h want 1", obs_ready); end
    n_cmp++; if (fifo_count !== 2'd2) begin n_err++; $display("FAIL full_push_next: got %0h want 2", fifo_count); end
    idle();
    tick();
    n_cmp++; if (rf_waddr !== 5'd11) begin n_err++; $display("FAIL full_drain1: got %0h want b", rf_waddr); end
    tick();
    n_cmp++; if (rf_waddr !== 5'd12) begin n_err++; $display("FAIL full_drain2: got %0h want c", rf_waddr); end
    tick();
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 7; i++) begin
      if (i < 5) set_mdu(1'b1, 5'(20 + i), 32'(32'hC0 + i));
      else set_mdu(1'b0, 5'd0, 32'd0);
      tick();
      if (i >= 1 && i <= 5) begin
        n_cmp++; if (rf_we !== 1'b1 || rf_waddr !== 5'(19 + i) || rf_wdata !== 32'(32'hBF + i)) begin
          n_err++; $display("FAIL wrap_order[%0d]: got we=%0h a=%0h d=%0h want we=1 a=%0h d=%0h",
                            i, rf_we, rf_waddr, rf_wdata, 19 + i, 32'hBF + i);
        end
      end
    end
  endtask

  task automatic test_nonwriting();
    set_pipe(1'b1, 1'b1, 5'd3, 32'h3);
    set_mdu(1'b1, 5'd20, 32'h20);
    tick();
    set_pipe(1'b1, 1'b1, 5'd4, 32'h4);
    set_mdu(1'b1, 5'd21, 32'h21);
    tick();
    for (int i = 0; i < 6; i++) begin
      set_pipe(1'b1, 1'b0, 5'($urandom_range(1, 31)), $urandom);
      set_mdu(1'b1, 5'(22 + i), 32'(i));
      tick();
      n_cmp++; if (obs_starve !== 1'b0) begin n_err++; $display("FAIL nw_starve[%0d]: got %0h want 0", i, obs_starve); end
      n_cmp++; if (rf_we !== 1'b1 || rf_waddr !== exp_waddr) begin
        n_err++; $display("FAIL nw_pop[%0d]: got we=%0h a=%0h want we=1 a=%0h", i, rf_we, rf_waddr, exp_waddr);
      end
    end
    idle();
    for (int i = 0; i < 4 && mq.size() != 0; i++) tick();
    n_cmp++; if (fifo_count !== 2'd0) begin n_err++; $display("FAIL nw_drained: got %0h want 0", fifo_count); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      set_pipe($urandom_range(0, 3) != 0, $urandom_range(0, 4) != 0,
               5'($urandom_range(0, 7) == 0 ? 0 : $urandom_range(1, 31)), $urandom);
      set_mdu($urandom_range(0, 2) == 0, 5'($urandom_range(0, 9) == 0 ? 0 : $urandom_range(1, 31)), $urandom);
      tick();
      n_cmp++; if (obs_allow !== exp_allow || obs_starve !== exp_starve || obs_ready !== exp_ready ||
                   obs_count_pre !== exp_count_pre) begin
        n_err++; $display("FAIL rand_comb[%0d]: got allow=%0h starve=%0h ready=%0h cnt=%0h want %0h %0h %0h %0h",
                          c, obs_allow, obs_starve, obs_ready, obs_count_pre, exp_allow, exp_starve, exp_ready, exp_count_pre);
      end
      n_cmp++; if (rf_we !== exp_we || rf_waddr !== exp_waddr || rf_wdata !== exp_wdata) begin
        n_err++; $display("FAIL rand_rf[%0d]: got we=%0h a=%0h d=%0h want we=%0h a=%0h d=%0h",
                          c, rf_we, rf_waddr, rf_wdata, exp_we, exp_waddr, exp_wdata);
      end
    end
  endtask

  task automatic test_reset_midop();
    set_pipe(1'b1, 1'b1, 5'd3, 32'h3);
    set_mdu(1'b1, 5'd13, 32'hD);
    tick();
    set_mdu(1'b1, 5'd14, 32'hE);
    tick();
    n_cmp++; if (fifo_count !== 2'd2) begin n_err++; $display("FAIL midrst_fill: got %0h want 2", fifo_count); end
    idle();
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (rf_we !== 1'b0) begin n_err++; $display("FAIL midrst_we: got %0h want 0", rf_we); end
    n_cmp++; if (fifo_count !== 2'd0) begin n_err++; $display("FAIL midrst_count: got %0h want 0", fifo_count); end
    n_cmp++; if (mdu_ready !== 1'b1) begin n_err++; $display("FAIL midrst_ready: got %0h want 1", mdu_ready); end
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    tick();
    n_cmp++; if (rf_we !== 1'b0) begin n_err++; $display("FAIL midrst_stale: got %0h want 0", rf_we); end
    tick();
    n_cmp++; if (rf_we !== 1'b0 || fifo_count !== 2'd0) begin
      n_err++; $display("FAIL midrst_quiet: got we=%0h cnt=%0h want 0 0", rf_we, fifo_count);
    end
  endtask

  initial begin
    rst = 1'b1;
    idle();
    model_reset();
    test_reset();
    test_pipe_only();
    test_mdu_only();
    test_starvation();
    test_full_fifo();
    test_wrap();
    test_nonwriting();
    test_random();
    test_reset_midop();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
- Shares the single regfile write port between the in-order pipeline writeback beat (MEM->WB) and a long-latency multiply/divide unit (MDU).
- MDU results are buffered in a small FIFO; the pipeline has priority.
- A starvation counter forces an MDU grant and stalls the pipeline with pipe_allow_in low.
- Sits between the wb stage and the regfile; the rf_* outputs drive the regfile write port and the ID bypass bus.

Parameters:
XLEN, 32, data width.
FIFO_DEPTH, 2, MDU result buffer entries (power of two, >=2).
MAX_WAIT, 3, cycles a non-empty FIFO head may be denied before it is force-granted (>=1).

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-high
pipe_valid  in  1  pipeline writeback beat present
pipe_allow_in  out  1  arbiter accepts the pipeline beat this cycle
pipe_we  in  1  pipeline beat writes the regfile
pipe_waddr  in  5  pipeline destination register
pipe_wdata  in  XLEN  pipeline write data
mdu_valid  in  1  MDU result offered
mdu_ready  out  1  FIFO can accept an MDU result
mdu_waddr  in  5  MDU destination register
mdu_wdata  in  XLEN  MDU result
rf_we  out  1  regfile write enable (registered)
rf_waddr  out  5  regfile write address (registered)
rf_wdata  out  XLEN  regfile write data (registered)
fifo_count  out  $clog2(FIFO_DEPTH+1)  occupied FIFO entries
starve_grant  out  1  a forced MDU grant is active this cycle (debug/perf)

Behaviour:
- Reset (async, rst=1): rf_we=0, rf_waddr=0, rf_wdata=0, fifo_count=0, wait_cnt=0, starve_grant=0.
  - Any in-flight FIFO contents are discarded.
  - Outputs hold their reset values until the first clk edge after rst deasserts.
- Requests:
  - pipe_req = pipe_valid & pipe_we & (pipe_waddr!=0).
  - fifo_req = (fifo_count!=0).
- Writes to x0:
  - A pipeline beat with pipe_waddr==0 is accepted and produces no write.
  - An MDU result with mdu_waddr==0 is accepted (handshake completes) and is NOT enqueued.
- Force condition: force = fifo_req & (wait_cnt==MAX_WAIT).
  - starve_grant = force.
  - pipe_allow_in = !force. This is combinational and independent of pipe_valid.
- Grant, in priority order:
  - force: FIFO head is granted.
  - else pipe_req: pipeline is granted.
  - else fifo_req: FIFO head is granted.
  - else: no grant.
- A pipeline beat is consumed when pipe_valid & pipe_allow_in. Non-writing beats (pipe_we=0) never block a FIFO grant in the same cycle.
- Outputs, updated at the edge after the grant cycle:
  - rf_we = 1 iff a grant occurred.
  - rf_waddr and rf_wdata take the granted source's values.
  - When there is no grant, rf_we=0 and rf_waddr/rf_wdata hold their previous values.
- Latency:
  - Pipeline beat accepted in cycle t: rf_we=1 in cycle t+1.
  - MDU push at the end of cycle t: earliest pop in t+1, rf_we=1 in t+2. There is no FIFO bypass.
- FIFO:
  - mdu_ready = (fifo_count < FIFO_DEPTH), computed from registered state only.
  - When full, mdu_ready=0 even if a pop occurs in the same cycle.
  - Push when mdu_valid & mdu_ready & (mdu_waddr!=0).
  - Pop on FIFO grant.
  - Simultaneous push and pop leaves the count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
  - Ordering is strictly FIFO.
- wait_cnt:
  - Cleared on a FIFO pop or when the FIFO is empty.
  - Incremented by 1 when fifo_req & no FIFO grant.
  - Saturates at MAX_WAIT.
  - After a forced grant it is cleared, so the next head must wait again.
- Same-register WAW/RAW ordering between pipeline and MDU is out of scope. ID stalls on an MDU-pending destination.

Decomposition:
- Shared header (cpu.vh/defines.v): `XLEN, `REG_ADDR_WIDTH (5), and the WB-to-ID bus width.
  - The {rf_we, rf_waddr, rf_wdata} packing matches `WB_TO_ID_BUS_WIDTH, so it can replace the wb stage bus.
- One sub-module: wb_arb_fifo.
  - Parameterized synchronous FIFO with async reset.
  - Ports: push/pop/full/empty/count, payload {waddr, wdata}.
- Arbitration, the starvation counter and the output registers live in the top module.

Test Plan:
- Reset mid-operation: FIFO holds 2 entries, assert rst asynchronously between edges -> rf_we=0, fifo_count=0, mdu_ready=1 immediately, with no stale write after release.
- Pipeline only: pipe beat {we=1, waddr=5, wdata=0xDEADBEEF} in cycle t -> rf_we=1, rf_waddr=5, rf_wdata=0xDEADBEEF in t+1. A beat with waddr=0 -> rf_we=0.
- MDU only: push {waddr=7, wdata=0x12345678} at cycle t -> fifo_count=1 in t+1, rf_we=1 / waddr=7 in t+2, fifo_count=0 in t+2.
- Starvation, MAX_WAIT=3: FIFO holds {r9, 0xA5}; the pipeline issues writing beats every cycle -> three pipeline writes, then pipe_allow_in=0 and starve_grant=1 for one cycle, then rf write r9=0xA5, then pipe_allow_in=1.
- Full FIFO: fill 2 entries while the pipeline blocks, hold mdu_valid=1 -> mdu_ready=0. With a pop and mdu_valid in the same cycle, no push occurs, and mdu_ready=1 the next cycle. Wrap-around: 5 back-to-back pushes/pops drain in order.
- Non-writing pipeline beats (pipe_we=0) every cycle with the FIFO non-empty -> FIFO pops every cycle, wait_cnt stays 0, starve_grant never asserts.
